// File: rtl/ultrasonic_scheduler_pkg.sv
// Shared definitions for the ultrasonic ranging scheduler: FSM encoding,
// distance conversion constants and the round-robin sensor index helper.
package ultrasonic_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE,
        ST_GAP
    } state_e;

    localparam int unsigned CYC_PER_CM = 58;
    localparam int unsigned CM_MAX     = 511;

    function automatic logic [1:0] next_sel(input logic [1:0] sel, input int unsigned n_sens);
        return (sel == 2'(n_sens - 1)) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage

// File: rtl/ultrasonic_scheduler_echo_sync.sv
// Two-flop synchronizer bringing the raw asynchronous echo lines into clk_1m.
module ultrasonic_scheduler_echo_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_1m,
    input  logic             rst,
    input  logic [WIDTH-1:0] echo_in,
    output logic [WIDTH-1:0] echo_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments with an asynchronous
    // active-low clear in the sensitivity list, so reset never waits for a clock.
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= echo_in;
            sync_q <= meta_q;
        end
    end

    assign echo_sync = sync_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 style scheduler: triggers one sensor per fixed-length
// slot, measures its echo width in centimetres and reports one result per slot.
module ultrasonic_scheduler
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int unsigned N_SENS   = 3,
    parameter int unsigned TRIG_US  = 10,
    parameter int unsigned ECHO_MAX = 25000,
    parameter int unsigned SLOT_US  = 60000,
    parameter int unsigned NEAR_CM  = 20
) (
    input  logic              clk_1m,
    input  logic              rst,
    input  logic              en,
    input  logic [N_SENS-1:0] echo,
    output logic [N_SENS-1:0] trig,
    output logic              res_valid,
    output logic [1:0]        res_id,
    output logic [8:0]        res_cm,
    output logic              res_timeout,
    output logic [N_SENS-1:0] near
);

    localparam int unsigned CNT_MAX = (ECHO_MAX > TRIG_US) ? ECHO_MAX : TRIG_US;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SLOT_W  = $clog2(SLOT_US);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0]  ECHO_LAST = CNT_W'(ECHO_MAX - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_US - 1);
    localparam logic [5:0]        SUB_LAST  = 6'(CYC_PER_CM - 1);
    localparam logic [8:0]        CM_SAT    = 9'(CM_MAX);
    localparam logic [9:0]        NEAR_TH   = 10'(NEAR_CM);

    logic [N_SENS-1:0] echo_s;
    logic              echo_sel;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        sub_q, sub_d;
    logic [8:0]        cm_q, cm_d;
    logic [1:0]        res_id_q, res_id_d;
    logic [8:0]        res_cm_q, res_cm_d;
    logic              res_to_q, res_to_d;
    logic [N_SENS-1:0] near_q, near_d;
    logic              go_done;
    logic              done_to;

    ultrasonic_scheduler_echo_sync #(
        .WIDTH(N_SENS)
    ) u_echo_sync (
        .clk_1m   (clk_1m),
        .rst      (rst),
        .echo_in  (echo),
        .echo_sync(echo_s)
    );

    assign echo_sel = echo_s[sel_q];

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        slot_d   = (state_q == ST_IDLE) ? slot_q : slot_q + SLOT_W'(1);
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        cm_d     = cm_q;
        res_id_d = res_id_q;
        res_cm_d = res_cm_q;
        res_to_d = res_to_q;
        near_d   = near_q;
        go_done  = 1'b0;
        done_to  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_TRIG;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                // The rise cycle itself is the first counted echo cycle.
                if (echo_sel) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                    sub_d   = 6'd1;
                    cm_d    = '0;
                end else if (cnt_q == ECHO_LAST) begin
                    go_done = 1'b1;
                    done_to = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!echo_sel) begin
                    go_done = 1'b1;
                end else if (cnt_q == ECHO_LAST) begin
                    go_done = 1'b1;
                    done_to = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cm_q != CM_SAT) cm_d = cm_q + 9'd1;
                    end else begin
                        sub_d = sub_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (slot_q == SLOT_LAST) begin
                    sel_d = next_sel(sel_q, N_SENS);
                    if (en) begin
                        state_d = ST_TRIG;
                        slot_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result registers load on entry to DONE so they are valid with res_valid.
        if (go_done) begin
            state_d        = ST_DONE;
            res_id_d       = sel_q;
            res_to_d       = done_to;
            res_cm_d       = done_to ? CM_SAT : cm_q;
            near_d[sel_q]  = !done_to && ({1'b0, cm_q} < NEAR_TH);
        end
    end

    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            slot_q   <= '0;
            cnt_q    <= '0;
            sub_q    <= '0;
            cm_q     <= '0;
            res_id_q <= '0;
            res_cm_q <= '0;
            res_to_q <= 1'b0;
            near_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            cm_q     <= cm_d;
            res_id_q <= res_id_d;
            res_cm_q <= res_cm_d;
            res_to_q <= res_to_d;
            near_q   <= near_d;
        end
    end

    // Decoded from the state register so reset forces all triggers low at once.
    always_comb begin
        trig = '0;
        if (state_q == ST_TRIG) trig[sel_q] = 1'b1;
    end

    assign res_valid   = (state_q == ST_DONE);
    assign res_id      = res_id_q;
    assign res_cm      = res_cm_q;
    assign res_timeout = res_to_q;
    assign near        = near_q;

endmodule
